// File: rtl/run_step_controller.sv
// rtl/run_step_controller.sv - run/step sequencer: switch sync, step debounce, 4-phase cycle commit, cycle counter, lamps
module run_step_controller #(
    parameter int DEBOUNCE_CYCLES = 16,  // stable clkX4 cycles before the step button is believed
    parameter int CNT_WIDTH       = 32   // width of cycleCount
) (
    input  logic                 clkX4,      // 4x clock
    input  logic                 rst,        // synchronous, active-high
    input  logic                 sigCH,      // run switch (async level)
    input  logic                 sigCE,      // master enable (async level)
    input  logic                 sigCP,      // step push-button (async, bouncing)
    input  logic                 haltIn,     // current instruction is HLT
    output logic [1:0]           phase,      // processor-cycle phase 0..3
    output logic                 cycleEn,    // commit strobe, phase 3 only
    output logic [CNT_WIDTH-1:0] cycleCount, // issued commit strobes
    output logic                 runLamp,    // state == RUN
    output logic                 haltLamp    // state == HALTED
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        STEP   = 2'd2,
        HALTED = 2'd3
    } state_t;

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic ch_meta, ch;
    logic ce_meta, ce;
    logic cp_meta, cp;

    logic            cp_prev;
    logic [DB_W-1:0] db_cnt;
    logic            cp_db;
    logic            step_pending;

    state_t state;
    state_t state_next;

    logic phase3;
    logic db_stable;
    logic db_take;
    logic step_edge;
    logic enter_step;

    assign phase3 = (phase == 2'd3);

    // The counter holds how many consecutive samples cp has matched its
    // previous sample; the debounced value only moves once that run is long
    // enough and the level actually differs from what is already held.
    assign db_stable = (cp == cp_prev);
    assign db_take   = db_stable && (db_cnt == DB_LAST) && (cp != cp_db);
    assign step_edge = db_take && cp;

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (ce && ch)
                    state_next = RUN;
                else if (ce && step_pending)
                    state_next = STEP;
            end
            RUN: begin
                if (haltIn)
                    state_next = HALTED;
                else if (!ch || !ce)
                    state_next = IDLE;
            end
            STEP: begin
                if (haltIn)
                    state_next = HALTED;
                else
                    state_next = IDLE;
            end
            default: state_next = HALTED;
        endcase
    end

    assign enter_step = phase3 && (state == IDLE) && (state_next == STEP);

    // Combinational so that haltIn presented during phase 3 can still veto
    // the commit of the HLT cycle; ce is deliberately absent so a started
    // cycle always finishes.
    assign cycleEn = phase3 && ((state == RUN) || (state == STEP)) && !haltIn;

    always_ff @(posedge clkX4) begin
        if (rst) begin
            ch_meta      <= 1'b0;
            ch           <= 1'b0;
            ce_meta      <= 1'b0;
            ce           <= 1'b0;
            cp_meta      <= 1'b0;
            cp           <= 1'b0;
            cp_prev      <= 1'b0;
            db_cnt       <= '0;
            cp_db        <= 1'b0;
            step_pending <= 1'b0;
            phase        <= 2'd0;
            state        <= IDLE;
            runLamp      <= 1'b0;
            haltLamp     <= 1'b0;
            cycleCount   <= '0;
        end else begin
            ch_meta <= sigCH;
            ch      <= ch_meta;
            ce_meta <= sigCE;
            ce      <= ce_meta;
            cp_meta <= sigCP;
            cp      <= cp_meta;

            cp_prev <= cp;
            if (!db_stable)
                db_cnt <= '0;
            else if (db_cnt != DB_LAST)
                db_cnt <= db_cnt + DB_W'(1);
            if (db_take)
                cp_db <= cp;

            // Clear wins over a simultaneous step edge so one press never
            // yields two steps.
            if (enter_step)
                step_pending <= 1'b0;
            else if (step_edge && ((state == IDLE) || (state == STEP)))
                step_pending <= 1'b1;

            phase <= phase + 2'd1;

            if (phase3) begin
                state    <= state_next;
                runLamp  <= (state_next == RUN);
                haltLamp <= (state_next == HALTED);
            end

            if (cycleEn)
                cycleCount <= cycleCount + CNT_WIDTH'(1);
        end
    end

endmodule
